// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between an instruction-fetch port (I)
// and a load/store port (D); D has priority, bounded by a starvation limit for I.
module ram_port_arbiter #(
    parameter int CPU_WIDTH    = 32,
    parameter int RAM_WIDTH    = 31,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   a_reset_n,

    input  logic                   i_req,
    input  logic [RAM_WIDTH-1:0]   i_addr,
    output logic                   i_gnt,
    output logic                   i_rsp_valid,
    output logic [CPU_WIDTH-1:0]   i_rdata,

    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [CPU_WIDTH/8-1:0] d_be,
    input  logic [RAM_WIDTH-1:0]   d_addr,
    input  logic [CPU_WIDTH-1:0]   d_wdata,
    output logic                   d_gnt,
    output logic                   d_rsp_valid,
    output logic [CPU_WIDTH-1:0]   d_rdata,

    output logic                   ram_en,
    output logic                   ram_we,
    output logic [CPU_WIDTH/8-1:0] ram_be,
    output logic [RAM_WIDTH-1:0]   ram_addr,
    output logic [CPU_WIDTH-1:0]   ram_wdata,
    input  logic [CPU_WIDTH-1:0]   ram_rdata
);

    localparam int          BE_W  = CPU_WIDTH / 8;
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    // Who was granted last cycle, i.e. who owns the read data arriving now.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t     owner;
    logic       wr_q;
    logic [3:0] starve_cnt;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (a_reset_n) begin
            if (d_req && (!i_req || starve_cnt < LIMIT))
                d_gnt = 1'b1;
            else if (i_req)
                i_gnt = 1'b1;
        end
    end

    always_comb begin
        ram_en    = i_gnt | d_gnt;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (d_gnt) begin
            ram_we    = d_we;
            ram_be    = d_be;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (i_gnt) begin
            ram_be    = {BE_W{1'b1}};
            ram_addr  = i_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            owner      <= OWN_NONE;
            wr_q       <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if (d_gnt)
                owner <= OWN_D;
            else if (i_gnt)
                owner <= OWN_I;
            else
                owner <= OWN_NONE;

            wr_q <= d_gnt & d_we;

            // Counts D grants that I has had to sit through; saturates at the limit.
            if (!i_req || i_gnt)
                starve_cnt <= 4'd0;
            else if (d_gnt && starve_cnt < LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign i_rsp_valid = (owner == OWN_I);
    assign d_rsp_valid = (owner == OWN_D);
    assign i_rdata     = i_rsp_valid ? ram_rdata : '0;
    // Writes complete with a response but return zero data.
    assign d_rdata     = (d_rsp_valid && !wr_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter: a reference arbiter and memory
// predict grants, RAM drive and routed read data; a monitor checks responses.
module tb_ram_port_arbiter;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int CW = 32;
    localparam int RW = 31;
    localparam int SL = 4;
    localparam int BW = CW / 8;

    logic          clk = 1'b0;
    logic          a_reset_n = 1'b0;
    logic          i_req = 1'b0;
    logic [RW-1:0] i_addr = '0;
    logic          i_gnt, i_rsp_valid;
    logic [CW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [RW-1:0] d_addr = '0;
    logic [CW-1:0] d_wdata = '0;
    logic          d_gnt, d_rsp_valid;
    logic [CW-1:0] d_rdata;
    logic          ram_en, ram_we;
    logic [BW-1:0] ram_be;
    logic [RW-1:0] ram_addr;
    logic [CW-1:0] ram_wdata;
    logic [CW-1:0] ram_rdata = '0;

    ram_port_arbiter #(.CPU_WIDTH(CW), .RAM_WIDTH(RW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .a_reset_n(a_reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] init_word(input int i);
        return 32'hA5C3_0F00 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Environment RAM: 16 words, indexed by byte address bits [5:2].
    logic          mem_init = 1'b1;
    logic [CW-1:0] env_mem [16];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) env_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= env_mem[ram_addr[5:2]];
            end
        end
    end

    // Reference model state
    logic [CW-1:0] ref_mem [16];
    logic [CW-1:0] i_q[$];
    logic [CW-1:0] d_q[$];
    int            d_wins = 0;   // D grants I has waited through
    logic          i_pend = 0, d_pend = 0;
    logic [RW-1:0] i_a = '0, d_a = '0;
    logic          d_w = 0;
    logic [BW-1:0] d_b = '0;
    logic [CW-1:0] d_wd = '0;

    task automatic new_i(input logic [RW-1:0] a);
        i_pend = 1'b1; i_a = a;
    endtask

    task automatic new_d(input logic we, input logic [BW-1:0] be, input logic [RW-1:0] a,
                         input logic [CW-1:0] wd);
        d_pend = 1'b1; d_w = we; d_b = be; d_a = a; d_wd = wd;
    endtask

    task automatic rand_i();
        new_i(RW'($urandom));
    endtask

    task automatic rand_d();
        new_d(1'($urandom), BW'($urandom), RW'($urandom), $urandom);
    endtask

    // mode: 0 random, 1 both ports always requesting, 2 no new requests
    task automatic step(input int mode, input bit do_rst);
        logic exp_i, exp_d;
        logic [68:0] exp_ram;
        @(posedge clk); #1;
        i_req   = i_pend;
        i_addr  = i_pend ? i_a : '0;
        d_req   = d_pend;
        d_we    = d_pend ? d_w : 1'b0;
        d_be    = d_pend ? d_b : '0;
        d_addr  = d_pend ? d_a : '0;
        d_wdata = d_pend ? d_wd : '0;
        @(negedge clk);

        if (i_pend && d_pend) exp_d = (d_wins < SL);
        else                  exp_d = d_pend;
        exp_i = i_pend && !exp_d;
        check("i_gnt", 128'(i_gnt), 128'(exp_i));
        check("d_gnt", 128'(d_gnt), 128'(exp_d));

        if (exp_d)      exp_ram = {1'b1, d_w, d_b, d_a, d_wd};
        else if (exp_i) exp_ram = {1'b1, 1'b0, {BW{1'b1}}, i_a, {CW{1'b0}}};
        else            exp_ram = '0;
        check("ram_drive", 128'({ram_en, ram_we, ram_be, ram_addr, ram_wdata}), 128'(exp_ram));

        if (exp_d) begin
            if (d_w) begin
                for (int b = 0; b < BW; b++)
                    if (d_b[b]) ref_mem[d_a[5:2]][8*b +: 8] = d_wd[8*b +: 8];
                d_q.push_back('0);
            end else begin
                d_q.push_back(ref_mem[d_a[5:2]]);
            end
            d_pend = 1'b0;
        end
        if (exp_i) begin
            i_q.push_back(ref_mem[i_a[5:2]]);
            i_pend = 1'b0;
        end
        if (!i_pend || exp_i) d_wins = 0;
        else if (exp_d && d_wins < SL) d_wins++;

        if (do_rst) begin
            a_reset_n = 1'b0;
            i_req = 1'b1;
            d_req = 1'b1;
            #0.4;
            check("rst_gnt", 128'({i_gnt, d_gnt, ram_en, ram_we}), 128'(0));
            check("rst_rsp", 128'({i_rsp_valid, d_rsp_valid}), 128'(0));
            #0.4;
            i_req = 1'b0;
            d_req = 1'b0;
            a_reset_n = 1'b1;
            i_pend = 1'b0;
            d_pend = 1'b0;
            i_q.delete();
            d_q.delete();
            d_wins = 0;
        end

        case (mode)
            0: begin
                if (!i_pend && ($urandom % 3) != 0) rand_i();
                if (!d_pend && ($urandom % 2) != 0) rand_d();
            end
            1: begin
                if (!i_pend) rand_i();
                if (!d_pend) rand_d();
            end
            default: ;
        endcase
    endtask

    // Response monitor: at most one response per port can be outstanding, and it
    // is due in the cycle right after its grant.
    initial begin
        logic exp_v;
        forever begin
            @(posedge clk); #3;
            exp_v = (i_q.size() > 0);
            check("i_rsp_valid", 128'(i_rsp_valid), 128'(exp_v));
            if (exp_v) check("i_rdata", 128'(i_rdata), 128'(i_q.pop_front()));
            else       check("i_rdata_idle", 128'(i_rdata), 128'(0));
            exp_v = (d_q.size() > 0);
            check("d_rsp_valid", 128'(d_rsp_valid), 128'(exp_v));
            if (exp_v) check("d_rdata", 128'(d_rdata), 128'(d_q.pop_front()));
            else       check("d_rdata_idle", 128'(d_rdata), 128'(0));
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // Reset: grants gated even with both requests asserted
        @(negedge clk);
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        check("reset_gnt", 128'({i_gnt, d_gnt, ram_en, ram_we}), 128'(0));
        check("reset_rsp", 128'({i_rsp_valid, d_rsp_valid}), 128'(0));
        @(negedge clk);
        i_req = 1'b0;
        d_req = 1'b0;
        a_reset_n = 1'b1;
        mem_init = 1'b0;

        // Seed 0x100 with DEADBEEF, then fetch it on three consecutive cycles
        new_d(1'b1, 4'hF, 31'h100, 32'hDEAD_BEEF);
        step(2, 0);
        for (int k = 0; k < 3; k++) begin
            new_i(31'h100);
            step(2, 0);
        end

        // Partial write returns a zero-data completion
        new_d(1'b1, 4'b0011, 31'h200, 32'h1234_5678);
        step(2, 0);

        // Alternating I and D reads, back to back
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) new_i(31'h10);
            else            new_d(1'b0, 4'hF, 31'h20, 32'h0);
            step(2, 0);
        end

        // Both ports saturated: D,D,D,D,I pattern
        rand_i();
        rand_d();
        for (int k = 0; k < 15; k++) step(1, 0);
        step(2, 0);
        step(2, 0);

        // Reset between a D read grant and its response edge
        new_d(1'b0, 4'hF, 31'h30, 32'h0);
        step(2, 1);
        step(2, 0);

        // Starvation count starts from zero after the reset
        rand_i();
        rand_d();
        for (int k = 0; k < 12; k++) step(1, 0);

        // Idle
        for (int k = 0; k < 12; k++) step(2, 0);

        // Random traffic
        for (int k = 0; k < 500; k++) step(0, 0);
        for (int k = 0; k < 8; k++) step(2, 0);

        @(posedge clk); #4;
        check("drain", 128'({i_pend, d_pend, 16'(i_q.size()), 16'(d_q.size())}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
